branch_predictor_2bit: RTL and testbench

- Parametrised next-generation fetch-stage predictor: direct-mapped BTB with valid bits, full-width targets and per-entry 2-bit saturating direction counters.
- Fetch queries it combinationally every cycle with the current PC.
- The EX stage writes it back with resolved branch outcomes.
- Carries saturating branch and mispredict statistics counters for performance bring-up.

---
 rtl/branch_predictor_2bit_pkg.sv | 22 ++
 rtl/branch_predictor_2bit_if.sv | 29 ++
 rtl/branch_predictor_2bit_sat_counter.sv | 22 ++
 rtl/branch_predictor_2bit.sv | 84 ++++++++
 tb/tb_branch_predictor_2bit.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_2bit_pkg.sv
// Shared types and helpers for the 2-bit BTB branch predictor.
// Counter states, reset/allocate states and the saturating step function.
package bp_pkg;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t BP_SNT = 2'b00;
    localparam bp_ctr_t BP_WNT = 2'b01;
    localparam bp_ctr_t BP_WT  = 2'b10;
    localparam bp_ctr_t BP_ST  = 2'b11;

    localparam bp_ctr_t BP_CTR_INIT  = BP_WNT;
    localparam bp_ctr_t BP_CTR_ALLOC = BP_WT;

    function automatic bp_ctr_t bp_sat(input bp_ctr_t s, input logic up);
        if (up) begin
            return (s == BP_ST) ? BP_ST : bp_ctr_t'(s + 2'd1);
        end
        return (s == BP_SNT) ? BP_SNT : bp_ctr_t'(s - 2'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_2bit_if.sv
// Fetch lookup, EX update and statistics bundle of the branch predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_2bit_if #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_W     = 16
);
    logic [WORD_SIZE-1:0] pc;
    logic                 btb_hit;
    logic                 pred_taken;
    logic [WORD_SIZE-1:0] pred_npc;
    logic                 upd_valid;
    logic [WORD_SIZE-1:0] upd_pc;
    logic                 upd_taken;
    logic [WORD_SIZE-1:0] upd_target;
    logic                 upd_mispredict;
    logic [CNT_W-1:0]     br_count;
    logic [CNT_W-1:0]     mp_count;

    modport master (
        output pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  btb_hit, pred_taken, pred_npc, br_count, mp_count
    );

    modport slave (
        input  pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        output btb_hit, pred_taken, pred_npc, br_count, mp_count
    );

endinterface

// File: rtl/branch_predictor_2bit_sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/branch_predictor_2bit.sv
// Direct-mapped BTB with 2-bit direction counters and branch statistics.
// Lookup is combinational from pc; updates land on the next clock edge.
module branch_predictor_2bit
    import bp_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int IDX_W     = 8,
    parameter int CNT_W     = 16
) (
    input logic                    clk,
    input logic                    reset,
    branch_predictor_2bit_if.slave bp
);
    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = WORD_SIZE - IDX_W;

    logic [N-1:0]         r_valid;
    logic [TAG_W-1:0]     r_tags    [N];
    logic [WORD_SIZE-1:0] r_targets [N];
    bp_ctr_t              r_ctr     [N];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_hit;
    logic             w_taken;
    logic             w_uhit;

    assign w_idx  = bp.pc[IDX_W-1:0];
    assign w_tag  = bp.pc[WORD_SIZE-1:IDX_W];
    assign w_uidx = bp.upd_pc[IDX_W-1:0];
    assign w_utag = bp.upd_pc[WORD_SIZE-1:IDX_W];

    always_comb begin
        w_hit   = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
        w_taken = w_hit && r_ctr[w_idx][1];
        w_uhit  = r_valid[w_uidx] && (r_tags[w_uidx] == w_utag);
    end

    assign bp.btb_hit    = w_hit;
    assign bp.pred_taken = w_taken;
    assign bp.pred_npc   = w_taken ? r_targets[w_idx]
                                   : bp.pc + WORD_SIZE'(1);

    // Reads above see pre-edge contents, so a same-index update is invisible until next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < N; i++) begin
                r_tags[i]    <= '0;
                r_targets[i] <= '0;
                r_ctr[i]     <= BP_CTR_INIT;
            end
        end else if (bp.upd_valid) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= bp_sat(r_ctr[w_uidx], bp.upd_taken);
                if (bp.upd_taken) begin
                    r_targets[w_uidx] <= bp.upd_target;
                end
            end else if (bp.upd_taken) begin
                r_valid[w_uidx]   <= 1'b1;
                r_tags[w_uidx]    <= w_utag;
                r_targets[w_uidx] <= bp.upd_target;
                r_ctr[w_uidx]     <= BP_CTR_ALLOC;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bp.upd_valid),
        .count (bp.br_count)
    );

    sat_counter #(.W(CNT_W)) u_mp_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bp.upd_valid && bp.upd_mispredict),
        .count (bp.mp_count)
    );

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Directed vector bench for branch_predictor_2bit, plus reset and counter saturation sequences.
module tb_branch_predictor_2bit;

    typedef struct {
        logic [15:0] pc;
        logic        uv;
        logic [15:0] upc;
        logic        ut;
        logic [15:0] utgt;
        logic        ump;
        logic        e_hit;
        logic        e_tk;
        logic [15:0] e_npc;
        logic [15:0] e_br;
        logic [15:0] e_mp;
    } vec_t;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    branch_predictor_2bit_if #(.WORD_SIZE(16), .CNT_W(16)) bus ();
    branch_predictor_2bit_if #(.WORD_SIZE(16), .CNT_W(4))  bus4 ();

    branch_predictor_2bit #(.WORD_SIZE(16), .IDX_W(8), .CNT_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bus)
    );

    branch_predictor_2bit #(.WORD_SIZE(16), .IDX_W(8), .CNT_W(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bp    (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] pc, input logic uv,
                         input logic [15:0] upc, input logic ut,
                         input logic [15:0] utgt, input logic ump);
        bus.pc             = pc;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_taken      = ut;
        bus.upd_target     = utgt;
        bus.upd_mispredict = ump;
    endtask

    vec_t vecs[$];

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        drive(16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        bus4.pc             = 16'h0000;
        bus4.upd_valid      = 1'b0;
        bus4.upd_pc         = 16'h0000;
        bus4.upd_taken      = 1'b0;
        bus4.upd_target     = 16'h0000;
        bus4.upd_mispredict = 1'b0;

        // pc, uv, upc, ut, utgt, ump | hit, tk, npc, br, mp (pre-edge)
        vecs.push_back('{16'h0012,0,16'h0000,0,16'h0000,0, 0,0,16'h0013,16'd0,16'd0});
        vecs.push_back('{16'hFFFF,0,16'h0000,0,16'h0000,0, 0,0,16'h0000,16'd0,16'd0});
        vecs.push_back('{16'h0012,1,16'h0012,1,16'h0040,1, 0,0,16'h0013,16'd0,16'd0});
        vecs.push_back('{16'h0012,1,16'h0012,0,16'h0000,0, 1,1,16'h0040,16'd1,16'd1});
        vecs.push_back('{16'h0012,1,16'h0012,0,16'h0000,0, 1,0,16'h0013,16'd2,16'd1});
        vecs.push_back('{16'h0012,1,16'h0012,0,16'h0000,0, 1,0,16'h0013,16'd3,16'd1});
        vecs.push_back('{16'h0012,1,16'h0012,1,16'h0040,0, 1,0,16'h0013,16'd4,16'd1});
        vecs.push_back('{16'h0012,1,16'h0012,1,16'h0040,0, 1,0,16'h0013,16'd5,16'd1});
        vecs.push_back('{16'h0012,1,16'h0012,1,16'h0040,0, 1,1,16'h0040,16'd6,16'd1});
        vecs.push_back('{16'h0012,1,16'h0012,1,16'h0040,0, 1,1,16'h0040,16'd7,16'd1});
        vecs.push_back('{16'h0012,1,16'h0012,0,16'h0000,0, 1,1,16'h0040,16'd8,16'd1});
        vecs.push_back('{16'h0012,1,16'h0012,0,16'h0000,0, 1,1,16'h0040,16'd9,16'd1});
        vecs.push_back('{16'h0012,1,16'h0012,1,16'h0040,0, 1,0,16'h0013,16'd10,16'd1});
        vecs.push_back('{16'h0112,0,16'h0000,0,16'h0000,0, 0,0,16'h0113,16'd11,16'd1});
        vecs.push_back('{16'h0012,1,16'h0112,0,16'h0000,1, 1,1,16'h0040,16'd11,16'd1});
        vecs.push_back('{16'h0012,0,16'h0000,0,16'h0000,0, 1,1,16'h0040,16'd12,16'd2});
        vecs.push_back('{16'h0112,1,16'h0112,1,16'h0200,1, 0,0,16'h0113,16'd12,16'd2});
        vecs.push_back('{16'h0112,0,16'h0000,0,16'h0000,0, 1,1,16'h0200,16'd13,16'd3});
        vecs.push_back('{16'h0012,0,16'h0000,0,16'h0000,0, 0,0,16'h0013,16'd13,16'd3});
        vecs.push_back('{16'h0012,1,16'h0012,1,16'h0080,0, 0,0,16'h0013,16'd13,16'd3});
        vecs.push_back('{16'h0012,1,16'h0012,1,16'h0090,0, 1,1,16'h0080,16'd14,16'd3});
        vecs.push_back('{16'h0012,0,16'h0000,0,16'h0000,0, 1,1,16'h0090,16'd15,16'd3});
        vecs.push_back('{16'h0012,0,16'h0012,0,16'h1234,1, 1,1,16'h0090,16'd15,16'd3});
        vecs.push_back('{16'h0012,0,16'h0000,0,16'h0000,0, 1,1,16'h0090,16'd15,16'd3});

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].pc, vecs[i].uv, vecs[i].upc, vecs[i].ut,
                  vecs[i].utgt, vecs[i].ump);
            #1;
            chk($sformatf("v%0d hit", i), 32'(bus.btb_hit), 32'(vecs[i].e_hit));
            chk($sformatf("v%0d taken", i), 32'(bus.pred_taken), 32'(vecs[i].e_tk));
            chk($sformatf("v%0d npc", i), 32'(bus.pred_npc), 32'(vecs[i].e_npc));
            chk($sformatf("v%0d br", i), 32'(bus.br_count), 32'(vecs[i].e_br));
            chk($sformatf("v%0d mp", i), 32'(bus.mp_count), 32'(vecs[i].e_mp));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset between edges, then updates ignored while held.
        drive(16'h0012, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        #1 chk("pre_rst hit", 32'(bus.btb_hit), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst hit", 32'(bus.btb_hit), 32'd0);
        chk("async_rst taken", 32'(bus.pred_taken), 32'd0);
        chk("async_rst npc", 32'(bus.pred_npc), 32'h0013);
        chk("async_rst br", 32'(bus.br_count), 32'd0);
        chk("async_rst mp", 32'(bus.mp_count), 32'd0);
        drive(16'h0012, 1'b1, 16'h0012, 1'b1, 16'h0555, 1'b1);
        @(posedge clk);
        #1;
        drive(16'h0012, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_hold hit", 32'(bus.btb_hit), 32'd0);
        chk("rst_hold npc", 32'(bus.pred_npc), 32'h0013);
        chk("rst_hold br", 32'(bus.br_count), 32'd0);
        chk("rst4 br", 32'(bus4.br_count), 32'd0);

        // Saturation of 4-bit statistics counters.
        @(posedge clk);
        #1;
        bus4.upd_valid      = 1'b1;
        bus4.upd_mispredict = 1'b1;
        for (int n = 0; n < 20; n++) begin
            bus4.upd_pc = 16'(n);
            @(posedge clk);
            #1;
            if (n == 13) begin
                chk("sat4 br@14", 32'(bus4.br_count), 32'hE);
            end
        end
        chk("sat4 br", 32'(bus4.br_count), 32'hF);
        chk("sat4 mp", 32'(bus4.mp_count), 32'hF);
        @(posedge clk);
        #1;
        chk("sat4 br hold", 32'(bus4.br_count), 32'hF);
        chk("sat4 mp hold", 32'(bus4.mp_count), 32'hF);
        bus4.upd_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
